seq_divider_nbit: RTL



---
 rtl/div_pkg.sv | 18 +
 rtl/sub_nbit.sv | 24 ++
 rtl/seq_divider_nbit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_N_DEFAULT     = 32;
  localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_N_DEFAULT + 1);

  // Counter must hold the value N itself, hence N+1 codes.
  function automatic int div_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sub_nbit.sv
// W-bit ripple subtractor: diff = a + ~b + 1, borrow_n = final carry (1 when a >= b).
module sub_nbit #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_n
);

  logic [W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic b_inv;
    assign b_inv      = ~b[i];
    assign diff[i]    = a[i] ^ b_inv ^ carry[i];
    assign carry[i+1] = (a[i] & b_inv) | (carry[i] & (a[i] ^ b_inv));
  end

  assign borrow_n = carry[W];

endmodule

// File: rtl/seq_divider_nbit.sv
// Iterative restoring divider, one trial subtraction per clock, start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating toward zero).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | N trial-subtraction cycles in progress
// DONE  | results just loaded, done pulse; start accepted here as in IDLE
module seq_divider_nbit
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CNT_W = div_cnt_w(N);

  div_state_e       state_q, state_d;
  logic [N-1:0]     rem_q, rem_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [N-1:0]     res_quo_q, res_quo_d;
  logic [N-1:0]     res_rem_q, res_rem_d;
  logic             dbz_q, dbz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [N:0]       trial;
  logic             unused_borrow_n;
  logic [N-1:0]     rem_next, quo_next;
  logic [N-1:0]     dd_mag, dv_mag, quo_fix, rem_fix;

  assign accept = start && (state_q != RUN);

  // The partial remainder stays below the divisor, so its top bit is always zero
  // and only N bits are stored; trial[N] carries the sign of the trial result.
  sub_nbit #(.W(N + 1)) u_trial_sub (
    .a        ({rem_q, dvd_q[N-1]}),
    .b        ({1'b0, dvs_q}),
    .diff     (trial),
    .borrow_n (unused_borrow_n)
  );

  assign rem_next = trial[N] ? {rem_q[N-2:0], dvd_q[N-1]} : trial[N-1:0];
  assign quo_next = {quo_q[N-2:0], ~trial[N]};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  assign dd_mag    = dividend[N-1] ? -dividend : dividend;
  assign dv_mag    = divisor[N-1]  ? -divisor  : divisor;
  assign quo_fix   = neg_quo_q ? -quo_next : quo_next;
  assign rem_fix   = neg_rem_q ? -rem_next : rem_next;
  assign neg_quo_d = accept ? (dividend[N-1] ^ divisor[N-1]) : neg_quo_q;
  assign neg_rem_d = accept ? dividend[N-1] : neg_rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  assign dd_mag  = dividend;
  assign dv_mag  = divisor;
  assign quo_fix = quo_next;
  assign rem_fix = rem_next;
`endif

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      RUN: begin
        rem_d = rem_next;
        quo_d = quo_next;
        dvd_d = {dvd_q[N-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = DONE;
          res_quo_d = quo_fix;
          res_rem_d = rem_fix;
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          rem_d = '0;
          dvd_d = dd_mag;
          dvs_d = dv_mag;
          quo_d = '0;
          cnt_d = CNT_W'(N);
          dbz_d = (divisor == '0);
          // Zero divisor skips the iteration entirely.
          if (divisor == '0) begin
            state_d   = DONE;
            res_quo_d = '1;
            res_rem_d = dividend;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      res_quo_q <= '0;
      res_rem_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = res_quo_q;
  assign remainder   = res_rem_q;
  assign div_by_zero = dbz_q;

endmodule
